// File: rtl/spy_bus_pkg.sv
// Shared definitions for the spy register bus arbiter.
//   state_t : arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   SPY_AW  : spy bus address width
//   SPY_DW  : spy bus data width
package spy_bus_pkg;

    localparam int SPY_AW = 4;
    localparam int SPY_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spy_rr_pick2.sv
// Two-way round-robin picker for spy bus masters.
//   req[1:0] in  : pending requests
//   rr       in  : requester favoured when both are pending
//   win      out : index of the chosen requester (meaningful when any=1)
//   any      out : at least one request pending
module spy_rr_pick2
    import spy_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    output logic       win,
    output logic       any
);

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        any = |req;
        win = req[1];
        if (req == 2'b11) begin
            win = rr;
        end
    end

endmodule

// File: rtl/spy_bus_arbiter.sv
// Two-port arbiter and sequencer for the 16-bit spy register bus.
// Each requester runs a four-phase req/ack handshake; the block issues one
// single-cycle dbread/dbwrite strobe per transaction and captures read data
// RD_LAT cycles after the strobe cycle.
//   clk, reset              : clock, asynchronous active-high reset
//   req/we/addr/wdata 0,1   : requester inputs, stable while req is high
//   ack0, ack1              : completion, held until the matching req drops
//   rdata                   : captured read data, valid while an ack is high
//   gnt, busy               : owning requester, FSM not idle
//   dbread, dbwrite         : spy bus strobes
//   eadr, spy_out           : spy address / write data, zero outside the strobe
//   spy_in                  : spy bus read data
module spy_bus_arbiter
    import spy_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [SPY_AW-1:0] addr0,
    input  logic [SPY_AW-1:0] addr1,
    input  logic [SPY_DW-1:0] wdata0,
    input  logic [SPY_DW-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [SPY_DW-1:0] rdata,
    output logic              gnt,
    output logic              busy,
    output logic              dbread,
    output logic              dbwrite,
    output logic [SPY_AW-1:0] eadr,
    output logic [SPY_DW-1:0] spy_out,
    input  logic [SPY_DW-1:0] spy_in
);

    localparam logic [2:0] LAT3 = 3'(RD_LAT);

    state_t            state;
    logic              rr;
    logic              cur_we;
    logic [2:0]        cnt;

    logic              win;
    logic              any;
    logic              pick_we;
    logic [SPY_AW-1:0] pick_addr;
    logic [SPY_DW-1:0] pick_wdata;
    logic              own_req;
    logic              capture_now;

    spy_rr_pick2 u_pick (
        .req ({req1, req0}),
        .rr  (rr),
        .win (win),
        .any (any)
    );

    assign pick_we    = win ? we1    : we0;
    assign pick_addr  = win ? addr1  : addr0;
    assign pick_wdata = win ? wdata1 : wdata0;
    assign own_req    = gnt ? req1   : req0;

    // The edge that samples spy_in: the end of ISSUE when there is no read
    // latency, otherwise the edge on which the wait count would reach zero.
    assign capture_now = ((state == ISSUE) && (RD_LAT == 0)) ||
                         ((state == WAIT)  && (cnt == 3'd1));

    // NOTE: all state here is plain flops, so every register is cleared by the
    // asynchronous reset; an aborted transaction leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr      <= 1'b0;
            cur_we  <= 1'b0;
            cnt     <= 3'd0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= '0;
            gnt     <= 1'b0;
            busy    <= 1'b0;
            dbread  <= 1'b0;
            dbwrite <= 1'b0;
            eadr    <= '0;
            spy_out <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= ISSUE;
                        gnt     <= win;
                        busy    <= 1'b1;
                        cur_we  <= pick_we;
                        // Strobe registered here so it is visible during ISSUE.
                        dbread  <= ~pick_we;
                        dbwrite <= pick_we;
                        eadr    <= pick_addr;
                        spy_out <= pick_we ? pick_wdata : '0;
                    end
                end
                ISSUE, WAIT: begin
                    if (state == ISSUE) begin
                        dbread  <= 1'b0;
                        dbwrite <= 1'b0;
                        eadr    <= '0;
                        spy_out <= '0;
                        cnt     <= LAT3;
                    end else begin
                        cnt     <= cnt - 3'd1;
                    end
                    if (capture_now) begin
                        state <= DONE;
                        ack0  <= ~gnt;
                        ack1  <= gnt;
                        if (!cur_we) begin
                            rdata <= spy_in;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    if (!own_req) begin
                        state <= IDLE;
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        busy  <= 1'b0;
                        rr    <= ~gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_bus_arbiter.sv
// Directed bench for spy_bus_arbiter. Three instances (RD_LAT = 1, 0, 3) share
// the same stimulus; most steps check the RD_LAT=1 instance, the latency sweep
// and reset steps check all three.
module tb_spy_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1, spy_in;

    logic        ack0_o    [3];
    logic        ack1_o    [3];
    logic        gnt_o     [3];
    logic        busy_o    [3];
    logic        dbread_o  [3];
    logic        dbwrite_o [3];
    logic [3:0]  eadr_o    [3];
    logic [15:0] rdata_o   [3];
    logic [15:0] spy_out_o [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spy_bus_arbiter #(.RD_LAT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
            .clk     (clk),
            .reset   (reset),
            .req0    (req0),
            .req1    (req1),
            .we0     (we0),
            .we1     (we1),
            .addr0   (addr0),
            .addr1   (addr1),
            .wdata0  (wdata0),
            .wdata1  (wdata1),
            .ack0    (ack0_o[g]),
            .ack1    (ack1_o[g]),
            .rdata   (rdata_o[g]),
            .gnt     (gnt_o[g]),
            .busy    (busy_o[g]),
            .dbread  (dbread_o[g]),
            .dbwrite (dbwrite_o[g]),
            .eadr    (eadr_o[g]),
            .spy_out (spy_out_o[g]),
            .spy_in  (spy_in)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_n      = 0;
    int   idle_viol   = 0;
    int   strobes  [3];
    int   acks     [3];
    int   ack0_rise[3];
    int   last_strobe;
    int   min_gap;
    logic gnt_log[$];
    logic seen0, seen1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int g = 0; g < 3; g++) begin
            strobes[g]   = 0;
            acks[g]      = 0;
            ack0_rise[g] = -1;
        end
        gnt_log.delete();
        last_strobe = -1;
        min_gap     = 1000;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        for (int g = 0; g < 3; g++) begin
            if (dbread_o[g] | dbwrite_o[g]) strobes[g]++;
            if (ack0_o[g] | ack1_o[g]) acks[g]++;
            if (!(dbread_o[g] | dbwrite_o[g]) && eadr_o[g] != 4'h0) idle_viol++;
            if (!dbwrite_o[g] && spy_out_o[g] != 16'h0) idle_viol++;
            if (ack0_o[g] && ack0_rise[g] < 0) ack0_rise[g] = tick_n;
        end
        if (dbread_o[0] | dbwrite_o[0]) begin
            gnt_log.push_back(gnt_o[0]);
            if (last_strobe >= 0 && (tick_n - last_strobe) < min_gap)
                min_gap = tick_n - last_strobe;
            last_strobe = tick_n;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req0   = 1'b0; req1   = 1'b0;
        we0    = 1'b0; we1    = 1'b0;
        addr0  = 4'h0; addr1  = 4'h0;
        wdata0 = 16'h0; wdata1 = 16'h0;
        spy_in = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        clear_stats();
        seen0 = 1'b0;
        seen1 = 1'b0;

        // Reset state
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 16'h0; wdata1 = 16'h0; spy_in = 16'h0;
        tick();
        check("rst_busy",  32'(busy_o[0]),  32'd0);
        check("rst_ack0",  32'(ack0_o[0]),  32'd0);
        check("rst_rdata", 32'(rdata_o[0]), 32'd0);
        check("rst_eadr",  32'(eadr_o[0]),  32'd0);
        do_reset();

        // Read from requester 0, RD_LAT=1
        clear_stats();
        spy_in = 16'hBEEF; we0 = 1'b0; addr0 = 4'h5; req0 = 1'b1;
        tick();
        check("rd_strobe", 32'(dbread_o[0]),  32'd1);
        check("rd_wrlow",  32'(dbwrite_o[0]), 32'd0);
        check("rd_eadr",   32'(eadr_o[0]),    32'h5);
        check("rd_gnt",    32'(gnt_o[0]),     32'd0);
        check("rd_busy",   32'(busy_o[0]),    32'd1);
        tick();
        check("rd_strobe_off", 32'(dbread_o[0]), 32'd0);
        check("rd_eadr_off",   32'(eadr_o[0]),   32'h0);
        check("rd_ack_early",  32'(ack0_o[0]),   32'd0);
        tick();
        check("rd_ack0",  32'(ack0_o[0]),  32'd1);
        check("rd_ack1",  32'(ack1_o[0]),  32'd0);
        check("rd_rdata", 32'(rdata_o[0]), 32'hBEEF);
        req0 = 1'b0;
        tick();
        check("rd_ack_drop",  32'(ack0_o[0]), 32'd0);
        check("rd_idle",      32'(busy_o[0]), 32'd0);
        check("rd_one_pulse", 32'(strobes[0]), 32'd1);

        // Write from requester 1
        do_reset();
        clear_stats();
        we1 = 1'b1; addr1 = 4'hA; wdata1 = 16'h1234; req1 = 1'b1;
        tick();
        check("wr_strobe",  32'(dbwrite_o[0]), 32'd1);
        check("wr_rdlow",   32'(dbread_o[0]),  32'd0);
        check("wr_eadr",    32'(eadr_o[0]),    32'hA);
        check("wr_spy_out", 32'(spy_out_o[0]), 32'h1234);
        check("wr_gnt",     32'(gnt_o[0]),     32'd1);
        tick();
        check("wr_strobe_off", 32'(dbwrite_o[0]), 32'd0);
        check("wr_data_off",   32'(spy_out_o[0]), 32'h0);
        tick();
        check("wr_ack1",  32'(ack1_o[0]),  32'd1);
        check("wr_ack0",  32'(ack0_o[0]),  32'd0);
        check("wr_rdata", 32'(rdata_o[0]), 32'h0);
        req1 = 1'b0;
        tick();
        check("wr_ack_drop",  32'(ack1_o[0]), 32'd0);
        check("wr_one_pulse", 32'(strobes[0]), 32'd1);

        // Contention: both requesters keep coming back; each drops req the
        // cycle after it sees ack and re-raises once ack is gone.
        do_reset();
        clear_stats();
        we0 = 1'b0; addr0 = 4'h1; we1 = 1'b1; addr1 = 4'h2; wdata1 = 16'h5555;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 80 && gnt_log.size() < 4; c++) begin
            tick();
            if (seen0) begin
                req0 = 1'b0; seen0 = 1'b0;
            end else if (ack0_o[0] && req0) begin
                seen0 = 1'b1;
            end else if (!req0 && !ack0_o[0]) begin
                req0 = 1'b1;
            end
            if (seen1) begin
                req1 = 1'b0; seen1 = 1'b0;
            end else if (ack1_o[0] && req1) begin
                seen1 = 1'b1;
            end else if (!req1 && !ack1_o[0]) begin
                req1 = 1'b1;
            end
        end
        check("cont_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < gnt_log.size(); i++) begin
            check($sformatf("cont_gnt%0d", i), 32'(gnt_log[i]), 32'(i % 2));
        end
        check("cont_gap", 32'(min_gap), 32'd5);
        req0 = 1'b0; req1 = 1'b0;

        // Latency sweep: spy_in steps every cycle; 0x2001 is the strobe-cycle value
        do_reset();
        clear_stats();
        we0 = 1'b0; addr0 = 4'h3; spy_in = 16'h2000; tick_n = 0; req0 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            spy_in = spy_in + 16'h1;
        end
        check("lat1_rdata", 32'(rdata_o[0]), 32'h2002);
        check("lat0_rdata", 32'(rdata_o[1]), 32'h2001);
        check("lat3_rdata", 32'(rdata_o[2]), 32'h2004);
        check("lat1_ack_at", 32'(ack0_rise[0]), 32'd3);
        check("lat0_ack_at", 32'(ack0_rise[1]), 32'd2);
        check("lat3_ack_at", 32'(ack0_rise[2]), 32'd5);
        check("lat3_ack_held", 32'(ack0_o[2]), 32'd1);
        check("lat0_one_pulse", 32'(strobes[1]), 32'd1);
        check("lat3_one_pulse", 32'(strobes[2]), 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        check("lat3_ack_drop", 32'(ack0_o[2]), 32'd0);
        check("lat3_idle",     32'(busy_o[2]), 32'd0);

        // Early req drop in the strobe cycle
        do_reset();
        clear_stats();
        spy_in = 16'hCAFE; we0 = 1'b0; addr0 = 4'h7; req0 = 1'b1;
        tick();
        check("drop_strobe", 32'(dbread_o[0]), 32'd1);
        req0 = 1'b0;
        tick();
        check("drop_ack_wait", 32'(ack0_o[0]), 32'd0);
        tick();
        check("drop_ack",   32'(ack0_o[0]),  32'd1);
        check("drop_rdata", 32'(rdata_o[0]), 32'hCAFE);
        tick();
        check("drop_ack_1cyc", 32'(ack0_o[0]), 32'd0);
        check("drop_idle",     32'(busy_o[0]), 32'd0);
        tick();
        tick();
        tick();
        check("drop_lat3_rdata", 32'(rdata_o[2]), 32'hCAFE);
        check("drop_lat3_acks",  32'(acks[2]),    32'd1);

        // Reset during WAIT (rr is 1 here after requester 0 completed)
        clear_stats();
        we1 = 1'b0; addr1 = 4'h2; req1 = 1'b1;
        tick();
        check("rw_gnt", 32'(gnt_o[0]), 32'd1);
        tick();
        check("rw_busy", 32'(busy_o[2]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rw_busy_clr%0d", g),  32'(busy_o[g]),  32'd0);
            check($sformatf("rw_rdata_clr%0d", g), 32'(rdata_o[g]), 32'd0);
            check($sformatf("rw_gnt_clr%0d", g),   32'(gnt_o[g]),   32'd0);
            check($sformatf("rw_ack_clr%0d", g),   32'(ack1_o[g]),  32'd0);
        end
        req1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_stats();
        for (int c = 0; c < 6; c++) tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rw_no_strobe%0d", g), 32'(strobes[g]), 32'd0);
            check($sformatf("rw_no_ack%0d", g),    32'(acks[g]),    32'd0);
        end
        we0 = 1'b0; addr0 = 4'h4; we1 = 1'b0; addr1 = 4'h6;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rw_rr0_gnt%0d", g), 32'(gnt_o[g]),  32'd0);
            check($sformatf("rw_rr0_eadr%0d", g), 32'(eadr_o[g]), 32'h4);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        check("zero_outside_strobe", 32'(idle_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
